// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch - instruction-fetch stage
//
// Generates the PC, fetches instruction words over a req/gnt/rvalid memory
// interface (one outstanding access), and presents {inst_o, pc_o} to the
// decode stage through a valid/ready IF/ID register. A one-entry hold register
// absorbs the response that arrives while decode is stalled. Redirects restart
// fetch at a new target and squash everything on the old path.
//
// Optional feature: define INST_FETCH_STATS_EN to add the fetch_cnt/stall_cnt
// statistics counters (ports and logic are absent otherwise).
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   imem_req      fetch request (registered)
//   imem_addr     word-aligned fetch address (registered)
//   imem_gnt      request accepted this cycle
//   imem_rvalid   response valid, one per grant
//   imem_rdata    response data
//   redirect      one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc   redirect target, low two bits ignored
//   id_ready      decode accepts inst_o this cycle
//   valid_o       inst_o/pc_o valid
//   inst_o, pc_o  instruction and its PC
//   fetch_cnt     instructions delivered to decode   (stats build only)
//   stall_cnt     cycles with valid_o && !id_ready    (stats build only)
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int              INST_W   = 32
`ifdef INST_FETCH_STATS_EN
    ,
    parameter int              CNT_W    = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o
`ifdef INST_FETCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(3'd4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic [INST_W-1:0] hold_inst_q, hold_inst_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic              valid_q, valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] pcout_q, pcout_d;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;

    logic gnt_s;
    logic outstanding_s;

    // A grant only counts while the request is actually being driven; this
    // masks the single REQ cycle right after reset where imem_req is still 0.
    assign gnt_s = req_q & imem_gnt;

    // An access remains in flight past this cycle if we are waiting and the
    // response has not arrived yet, or a new request is granted right now.
    assign outstanding_s = ((state_q == ST_WAIT) && !imem_rvalid) ||
                           ((state_q == ST_REQ) && gnt_s);

    // Next-state logic for the fetch FSM, PC, hold and IF/ID registers.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        inst_d      = inst_q;
        pcout_d     = pcout_q;
        valid_d     = valid_q;

        if (redirect) begin
            // Squash the old path; an in-flight access must still be drained,
            // so wait for it with drop set instead of issuing a new request.
            pc_d    = redirect_pc & ALIGN_MASK;
            valid_d = 1'b0;
            if (outstanding_s) begin
                state_d = ST_WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = ST_REQ;
                drop_d  = 1'b0;
            end
        end else begin
            // A consumed IF/ID entry empties unless reloaded below.
            if (valid_q && id_ready) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end

            case (state_q)
                ST_REQ: begin
                    if (gnt_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_REQ;
                        end else if (!valid_q || id_ready) begin
                            inst_d  = imem_rdata;
                            pcout_d = pc_q;
                            valid_d = 1'b1;
                            pc_d    = pc_q + PC_STEP;
                            state_d = ST_REQ;
                        end else begin
                            hold_inst_d = imem_rdata;
                            hold_pc_d   = pc_q;
                            pc_d        = pc_q + PC_STEP;
                            state_d     = ST_HOLD;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    // valid_q is always set here, so id_ready means a transfer.
                    if (id_ready) begin
                        inst_d  = hold_inst_q;
                        pcout_d = hold_pc_q;
                        valid_d = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                    drop_d  = 1'b0;
                end
            endcase
        end
    end

    // State registers; imem_req/imem_addr are registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            hold_inst_q <= {INST_W{1'b0}};
            hold_pc_q   <= {ADDR_W{1'b0}};
            valid_q     <= 1'b0;
            inst_q      <= {INST_W{1'b0}};
            pcout_q     <= {ADDR_W{1'b0}};
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            pcout_q     <= pcout_d;
            req_q       <= (state_d == ST_REQ);
            addr_q      <= pc_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign valid_o   = valid_q;
    assign inst_o    = inst_q;
    assign pc_o      = pcout_q;

`ifdef INST_FETCH_STATS_EN
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Statistics: a transfer in a redirect cycle is squashed and not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= {CNT_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (valid_q && id_ready && !redirect) begin
                fetch_cnt_q <= fetch_cnt_q + CNT_W'(1'b1);
            end else begin
                fetch_cnt_q <= fetch_cnt_q;
            end
            if (valid_q && !id_ready) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1'b1);
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch - bench for inst_fetch
//
// A memory responder with random grant/latency drives the DUT. The reference
// model is transaction level: delivered instructions must form the sequential
// stream from the last restart point (reset or redirect target), each carrying
// the memory word at its PC. A second instance built with a PC near the top of
// the address space checks the wrap.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt = 1'b0;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = 32'h0;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
`ifdef INST_FETCH_STATS_EN
    logic [31:0] fetch_cnt, stall_cnt, w_fcnt, w_scnt;
`endif

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .valid_o(valid_o), .inst_o(inst_o), .pc_o(pc_o)
`ifdef INST_FETCH_STATS_EN
        , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect(1'b0), .redirect_pc(32'h0), .id_ready(1'b1),
        .valid_o(w_valid), .inst_o(w_inst), .pc_o(w_pc)
`ifdef INST_FETCH_STATS_EN
        , .fetch_cnt(w_fcnt), .stall_cnt(w_scnt)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int deliv = 0;
    int exp_fetch = 0;
    int exp_stall = 0;
    int idle = 0;

    // memory responder state
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_d = 0;
    logic        w_pend = 1'b0;
    logic [31:0] w_paddr = 32'h0;

    // reference model
    logic [31:0] exp_pc = 32'h0;

    // previous-cycle observations
    logic        prev_rst = 1'b1;
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_redirect = 1'b0;
    logic        prev_req = 1'b0, prev_gnt = 1'b0;
    logic [31:0] prev_inst = 32'h0, prev_pc = 32'h0, prev_addr = 32'h0;

    // knobs
    int          ready_mode = 1;   // 0 random, 1 always, 2 never
    int          gnt_mode = 1;     // 0 random, 1 always
    int          lat_fix = 0;      // -1 random 0..2, else fixed extra cycles
    int          redir_prob = 0;
    int          rst_prob = 0;
    logic        rst_req = 1'b1;
    logic        redir_on_valid = 1'b0;
    logic        redir_hit = 1'b0;
    logic [31:0] redir_target = 32'h0;

    logic [31:0] glog[$];
    int          gcyc[$];
    logic [31:0] w_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_00FF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom & 32'h0000_0FFF;
        if ($urandom_range(3, 0) == 0) t = t | 32'hFFFF_F000;
        return t;
    endfunction

    // One clock: observe outputs at the falling edge, then drive inputs.
    task automatic step();
        logic deliver;
        @(negedge clk);
        cyc++;
        if (prev_rst) begin
            chk("rst_valid", {31'b0, valid_o}, 32'd0);
            chk("rst_req", {31'b0, imem_req}, 32'd0);
        end else begin
            if (prev_redirect) begin
                chk("redir_clears_valid", {31'b0, valid_o}, 32'd0);
            end else if (prev_valid && !prev_ready) begin
                chk("stall_valid", {31'b0, valid_o}, 32'd1);
                chk("stall_inst", inst_o, prev_inst);
                chk("stall_pc", pc_o, prev_pc);
            end
            if (prev_req && !prev_gnt && !prev_redirect) begin
                chk("req_held", {31'b0, imem_req}, 32'd1);
                chk("addr_held", imem_addr, prev_addr);
            end
            if (pend) chk("one_outstanding", {31'b0, imem_req}, 32'd0);
        end
        if (imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
`ifdef INST_FETCH_STATS_EN
        chk("fetch_cnt", fetch_cnt, exp_fetch);
        chk("stall_cnt", stall_cnt, exp_stall);
`endif

        rst = rst_req || (rst_prob != 0 && $urandom_range(rst_prob - 1, 0) == 0);
        if (rst) begin
            imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
            redirect = 1'b0; id_ready = 1'b0; pend = 1'b0;
            exp_pc = 32'h0; exp_fetch = 0; exp_stall = 0; idle = 0;
            w_gnt = 1'b0; w_rvalid = 1'b0; w_pend = 1'b0;
            glog.delete(); gcyc.delete(); w_log.delete();
        end else begin
            case (ready_mode)
                1: id_ready = 1'b1;
                2: id_ready = 1'b0;
                default: id_ready = ($urandom_range(3, 0) != 0);
            endcase
            redirect = (redir_prob != 0 && $urandom_range(redir_prob - 1, 0) == 0);
            redirect_pc = rand_target();
            if (redir_on_valid && valid_o) begin
                redirect = 1'b1;
                redirect_pc = redir_target;
                redir_on_valid = 1'b0;
                redir_hit = 1'b1;
            end
            if (pend && pend_d == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem_word(pend_addr);
                pend = 1'b0;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata = $urandom;
                if (pend) pend_d--;
            end
            if (imem_req && (gnt_mode == 1 || $urandom_range(1, 0) == 1)) begin
                imem_gnt = 1'b1;
                pend = 1'b1;
                pend_addr = imem_addr;
                pend_d = (lat_fix >= 0) ? lat_fix : $urandom_range(2, 0);
                glog.push_back(imem_addr);
                gcyc.push_back(cyc);
            end else begin
                imem_gnt = 1'b0;
            end

            deliver = valid_o && id_ready && !redirect;
            if (deliver) begin
                chk("deliver_pc", pc_o, exp_pc);
                chk("deliver_inst", inst_o, mem_word(pc_o));
                exp_pc = exp_pc + 32'd4;
                deliv++; exp_fetch++; idle = 0;
            end else begin
                idle++;
            end
            if (valid_o && !id_ready) exp_stall++;
            if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            if (idle > 200) begin
                chk("idle_cycles", idle, 32'd0);
                idle = 0;
            end

            w_rvalid = w_pend;
            w_rdata = mem_word(w_paddr);
            w_gnt = w_req;
            if (w_req) begin
                w_pend = 1'b1;
                w_paddr = w_addr;
                if (w_log.size() < 3) w_log.push_back(w_addr);
            end else begin
                w_pend = 1'b0;
            end
        end

        prev_rst = rst; prev_valid = valid_o; prev_ready = id_ready;
        prev_redirect = redirect; prev_inst = inst_o; prev_pc = pc_o;
        prev_req = imem_req; prev_gnt = imem_gnt; prev_addr = imem_addr;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int rel_cyc, d0, gl;
        // ---- reset and 1-cycle memory streaming ----
        rst_req = 1'b1;
        repeat (3) step();
        chk("reset_valid", {31'b0, valid_o}, 32'd0);
        chk("reset_req", {31'b0, imem_req}, 32'd0);
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_inst", inst_o, 32'h0);
        chk("reset_pc", pc_o, 32'h0);
        rst_req = 1'b0; gnt_mode = 1; lat_fix = 0; ready_mode = 1;
        step();
        rel_cyc = cyc;
        repeat (8) step();
        chk("t1_ngrants", (glog.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        if (glog.size() >= 3) begin
            chk("t1_first_req_delay", gcyc[0] - rel_cyc, 32'd1);
            chk("t1_addr0", glog[0], 32'h0);
            chk("t1_addr1", glog[1], 32'h4);
            chk("t1_addr2", glog[2], 32'h8);
            chk("t1_spacing1", gcyc[1] - gcyc[0], 32'd2);
            chk("t1_spacing2", gcyc[2] - gcyc[1], 32'd2);
        end
        chk("t5_nwrap", w_log.size(), 32'd3);
        if (w_log.size() == 3) begin
            chk("t5_addr0", w_log[0], 32'hFFFF_FFF8);
            chk("t5_addr1", w_log[1], 32'hFFFF_FFFC);
            chk("t5_addr2", w_log[2], 32'h0000_0000);
        end

        // ---- decode stall fills the hold register ----
        ready_mode = 2;
        repeat (6) step();
        chk("t2_valid_held", {31'b0, valid_o}, 32'd1);
        chk("t2_no_req_in_hold", {31'b0, imem_req}, 32'd0);
        ready_mode = 1;
        d0 = deliv;
        step();
        step();
        chk("t2_two_delivered", deliv - d0, 32'd2);

        // ---- redirect while an access with 3-cycle latency is outstanding ----
        lat_fix = 2;
        for (int i = 0; i < 20 && !pend; i++) step();
        chk("t3_pending", {31'b0, pend}, 32'd1);
        redir_target = 32'h100;
        redir_on_valid = 1'b0;
        prev_redirect = 1'b0;
        begin
            // force the redirect on the next cycle regardless of valid_o
            redir_prob = 0;
            @(negedge clk);
        end
        cyc++;
        redirect = 1'b1; redirect_pc = 32'h100;
        id_ready = 1'b1; imem_gnt = 1'b0;
        if (valid_o) chk("t3_no_deliver_count", {31'b0, redirect}, 32'd1);
        if (pend && pend_d == 0) begin
            imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr); pend = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (pend) pend_d--;
        end
        if (valid_o && !id_ready) exp_stall++;
        exp_pc = 32'h100;
        prev_rst = 1'b0; prev_valid = valid_o; prev_ready = 1'b1; prev_redirect = 1'b1;
        prev_inst = inst_o; prev_pc = pc_o; prev_req = imem_req; prev_gnt = 1'b0;
        prev_addr = imem_addr;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valid_o) break;
        end
        chk("t3_valid_after", {31'b0, valid_o}, 32'd1);
        chk("t3_pc_after", pc_o, 32'h100);

        // ---- redirect coinciding with a transfer ----
        lat_fix = 0;
        redir_target = 32'h203;
        redir_hit = 1'b0;
        redir_on_valid = 1'b1;
        for (int i = 0; i < 20 && !redir_hit; i++) step();
        chk("t4_redirect_hit", {31'b0, redir_hit}, 32'd1);
        redir_on_valid = 1'b0;
        gl = glog.size();
        d0 = exp_fetch;
        step();
        chk("t4_valid_cleared", {31'b0, valid_o}, 32'd0);
`ifdef INST_FETCH_STATS_EN
        chk("t4_squash_not_counted", fetch_cnt, d0);
`endif
        for (int i = 0; i < 20 && glog.size() <= gl; i++) step();
        chk("t4_next_addr", (glog.size() > gl) ? glog[gl] : 32'hDEAD_BEEF, 32'h200);

`ifdef INST_FETCH_STATS_EN
        // ---- statistics counters ----
        rst_req = 1'b1; step(); step();
        rst_req = 1'b0; step();
        ready_mode = 1;
        for (int i = 0; i < 100 && exp_fetch < 6; i++) step();
        ready_mode = 2;
        for (int i = 0; i < 50 && exp_stall < 4; i++) step();
        ready_mode = 1;
        for (int i = 0; i < 100 && exp_fetch < 10; i++) step();
        @(posedge clk);
        #1;
        chk("t6_fetch_cnt", fetch_cnt, 32'd10);
        chk("t6_stall_cnt", stall_cnt, 32'd4);
        rst_req = 1'b1; step(); step();
        chk("t6_fetch_rst", fetch_cnt, 32'd0);
        chk("t6_stall_rst", stall_cnt, 32'd0);
        rst_req = 1'b0;
`endif

        // ---- randomized traffic ----
        ready_mode = 0; gnt_mode = 0; lat_fix = -1;
        redir_prob = 12; rst_prob = 300;
        d0 = deliv;
        repeat (3000) step();
        redir_prob = 0; rst_prob = 0;
        chk("random_progress", (deliv - d0 > 200) ? 32'd1 : 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
